mm_cfg_master: RTL and testbench

Memory-mapped initiator that drives the QoS register block's `mm_write_en`/`mm_read_en`/`mm_addr`/`mm_wdata` bus and captures `mm_rdata`. After reset it writes a boot configuration to address 0x00. It then arbitrates between host command requests and a periodic autonomous poll of the status (0x01) and error-count (0x02) registers. It sits between the board controller (or UART/JTAG bridge) and the register slave.

---
 rtl/mm_cfg_master.sv | 267 ++++++++++++++++++++++++++
 tb/tb_mm_cfg_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_cfg_master.sv
// Memory-mapped initiator for the QoS register block: boot write, host commands, periodic status/error poll.
// The poll timer and POLL* states are present only when MM_CFG_MASTER_AUTOPOLL_EN is defined.
module mm_cfg_master #(
    parameter int unsigned POLL_PERIOD = 1000,
    parameter int unsigned RD_LATENCY  = 1,
    parameter logic [31:0] CFG_INIT    = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        mm_write_en,
    output logic        mm_read_en,
    output logic [7:0]  mm_addr,
    output logic [31:0] mm_wdata,
    input  logic [31:0] mm_rdata,
    output logic [31:0] status_word,
    output logic [31:0] error_word,
    output logic        status_valid,
    output logic        poll_overrun,
    output logic        busy
);

    if (POLL_PERIOD < 8 || POLL_PERIOD > 1048576 || RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_param_err
        $error("mm_cfg_master: POLL_PERIOD or RD_LATENCY out of range");
    end

    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

`ifdef MM_CFG_MASTER_AUTOPOLL_EN
    typedef enum logic [3:0] {
        BOOT_WR, IDLE, CMD_WR, CMD_RD, CMD_WAIT,
        POLL1_RD, POLL1_WAIT, POLL2_RD, POLL2_WAIT
    } state_t;
`else
    typedef enum logic [2:0] {
        BOOT_WR, IDLE, CMD_WR, CMD_RD, CMD_WAIT
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [1:0]  wait_q, wait_d;
    logic [7:0]  cmd_addr_q;
    logic [31:0] cmd_wdata_q;
    logic [7:0]  mm_addr_q;
    logic [31:0] mm_wdata_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_vld_q;

    logic        cmd_ready_c;
    logic        cmd_accept;
    logic        wr_stb;
    logic        rd_stb;
    logic        wr_rsp;
    logic        cap_cmd;
    logic        wait_last;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        poll_pending;

`ifdef MM_CFG_MASTER_AUTOPOLL_EN
    localparam logic [19:0] TIMER_LAST = 20'(POLL_PERIOD - 1);

    logic [19:0] timer_q;
    logic        poll_pending_q;
    logic        poll_overrun_q;
    logic [31:0] shadow_q;
    logic [31:0] status_word_q;
    logic [31:0] error_word_q;
    logic        status_valid_q;
    logic        cap_p1;
    logic        cap_p2;
    logic        in_poll;
    logic        wrap;
`endif

    assign wait_last = (wait_q == WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        cmd_ready_c = 1'b0;
        cmd_accept  = 1'b0;
        wr_stb      = 1'b0;
        rd_stb      = 1'b0;
        wr_rsp      = 1'b0;
        cap_cmd     = 1'b0;
        bus_addr    = mm_addr_q;
        bus_wdata   = mm_wdata_q;
`ifdef MM_CFG_MASTER_AUTOPOLL_EN
        cap_p1      = 1'b0;
        cap_p2      = 1'b0;
`endif
        case (state_q)
            BOOT_WR: begin
                wr_stb    = 1'b1;
                bus_addr  = 8'h00;
                bus_wdata = CFG_INIT;
                state_d   = IDLE;
            end
            IDLE: begin
`ifdef MM_CFG_MASTER_AUTOPOLL_EN
                if (poll_pending) begin
                    state_d = POLL1_RD;
                end else begin
`else
                begin
`endif
                    cmd_ready_c = 1'b1;
                    if (cmd_valid) begin
                        cmd_accept = 1'b1;
                        state_d    = cmd_write ? CMD_WR : CMD_RD;
                    end
                end
            end
            CMD_WR: begin
                wr_stb    = 1'b1;
                wr_rsp    = 1'b1;
                bus_addr  = cmd_addr_q;
                bus_wdata = cmd_wdata_q;
                state_d   = IDLE;
            end
            CMD_RD: begin
                rd_stb   = 1'b1;
                bus_addr = cmd_addr_q;
                wait_d   = 2'd0;
                state_d  = CMD_WAIT;
            end
            CMD_WAIT: begin
                if (wait_last) begin
                    cap_cmd = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
`ifdef MM_CFG_MASTER_AUTOPOLL_EN
            POLL1_RD: begin
                rd_stb   = 1'b1;
                bus_addr = 8'h01;
                wait_d   = 2'd0;
                state_d  = POLL1_WAIT;
            end
            POLL1_WAIT: begin
                if (wait_last) begin
                    cap_p1  = 1'b1;
                    state_d = POLL2_RD;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            POLL2_RD: begin
                rd_stb   = 1'b1;
                bus_addr = 8'h02;
                wait_d   = 2'd0;
                state_d  = POLL2_WAIT;
            end
            POLL2_WAIT: begin
                if (wait_last) begin
                    cap_p2  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT_WR;
            wait_q      <= 2'd0;
            cmd_addr_q  <= 8'h00;
            cmd_wdata_q <= 32'h0;
            mm_addr_q   <= 8'h00;
            mm_wdata_q  <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            mm_addr_q  <= bus_addr;
            mm_wdata_q <= bus_wdata;
            rsp_vld_q  <= cap_cmd;
            if (cmd_accept) begin
                cmd_addr_q  <= cmd_addr;
                cmd_wdata_q <= cmd_wdata;
            end
            if (cmd_accept && cmd_write) begin
                rsp_rdata_q <= 32'h0;
            end else if (cap_cmd) begin
                rsp_rdata_q <= mm_rdata;
            end
        end
    end

`ifdef MM_CFG_MASTER_AUTOPOLL_EN
    assign in_poll = (state_q == POLL1_RD) || (state_q == POLL1_WAIT) ||
                     (state_q == POLL2_RD) || (state_q == POLL2_WAIT);
    assign wrap    = (state_q != BOOT_WR) && (timer_q == TIMER_LAST);

    // A wrap while a poll is queued or running is recorded, never queued a second time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q        <= 20'd0;
            poll_pending_q <= 1'b0;
            poll_overrun_q <= 1'b0;
            shadow_q       <= 32'h0;
            status_word_q  <= 32'h0;
            error_word_q   <= 32'h0;
            status_valid_q <= 1'b0;
        end else begin
            if (wrap) begin
                timer_q <= 20'd0;
            end else if (state_q != BOOT_WR) begin
                timer_q <= timer_q + 20'd1;
            end
            if (wrap && !poll_pending_q && !in_poll) begin
                poll_pending_q <= 1'b1;
            end else if (state_q == POLL1_RD) begin
                poll_pending_q <= 1'b0;
            end
            if (wrap && (poll_pending_q || in_poll)) begin
                poll_overrun_q <= 1'b1;
            end
            if (cap_p1) begin
                shadow_q <= mm_rdata;
            end
            if (cap_p2) begin
                status_word_q <= shadow_q;
                error_word_q  <= mm_rdata;
            end
            status_valid_q <= cap_p2;
        end
    end

    assign poll_pending = poll_pending_q;
    assign status_word  = status_word_q;
    assign error_word   = error_word_q;
    assign status_valid = status_valid_q;
    assign poll_overrun = poll_overrun_q;
`else
    assign poll_pending = 1'b0;
    assign status_word  = 32'h0;
    assign error_word   = 32'h0;
    assign status_valid = 1'b0;
    assign poll_overrun = 1'b0;
`endif

    // State resets to BOOT_WR, so combinational outputs are masked while rst is held.
    assign cmd_ready   = cmd_ready_c & ~rst;
    assign mm_write_en = wr_stb & ~rst;
    assign mm_read_en  = rd_stb & ~rst;
    assign mm_addr     = rst ? mm_addr_q  : bus_addr;
    assign mm_wdata    = rst ? mm_wdata_q : bus_wdata;
    assign busy        = (state_q != IDLE) & ~rst;
    assign rsp_valid   = wr_rsp | rsp_vld_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_mm_cfg_master.sv
// Bench for mm_cfg_master: RAM slave model, response scoreboard, poll and reset scenarios.
module tb_mm_cfg_master;
    localparam int RDL = 1;
    localparam int PER = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        mm_write_en, mm_read_en;
    logic [7:0]  mm_addr;
    logic [31:0] mm_wdata, mm_rdata;
    logic [31:0] status_word, error_word;
    logic        status_valid, poll_overrun, busy;

    logic        cmd_valid2, cmd_ready2;
    logic        rsp_valid2;
    logic [31:0] rsp_rdata2;
    logic        mm_write_en2, mm_read_en2;
    logic [7:0]  mm_addr2;
    logic [31:0] mm_wdata2;
    logic [31:0] status_word2, error_word2;
    logic        status_valid2, poll_overrun2, busy2;

    mm_cfg_master #(.POLL_PERIOD(PER), .RD_LATENCY(RDL), .CFG_INIT(32'h0000_0001)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mm_write_en(mm_write_en), .mm_read_en(mm_read_en), .mm_addr(mm_addr),
        .mm_wdata(mm_wdata), .mm_rdata(mm_rdata),
        .status_word(status_word), .error_word(error_word), .status_valid(status_valid),
        .poll_overrun(poll_overrun), .busy(busy)
    );

    mm_cfg_master #(.POLL_PERIOD(8), .RD_LATENCY(4), .CFG_INIT(32'h0000_0001)) dut2 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(1'b0),
        .cmd_addr(8'h01), .cmd_wdata(32'h0),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
        .mm_write_en(mm_write_en2), .mm_read_en(mm_read_en2), .mm_addr(mm_addr2),
        .mm_wdata(mm_wdata2), .mm_rdata(32'h5A5A_0000),
        .status_word(status_word2), .error_word(error_word2), .status_valid(status_valid2),
        .poll_overrun(poll_overrun2), .busy(busy2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM slave: read data appears the cycle after the strobe and holds until the next read.
    logic [31:0] smem [0:3];
    logic [1:0]  rd_idx;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) smem[i] <= 32'h0;
            rd_idx <= 2'd0;
        end else begin
            if (mm_write_en) smem[mm_addr[1:0]] <= mm_wdata;
            if (mm_read_en) rd_idx <= mm_addr[1:0];
        end
    end
    assign mm_rdata = smem[rd_idx];

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [0:3];
    int          rsp_cnt  = 0;
    int          rsp2_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            ref_mem[0] = 32'h0000_0001;
            for (int i = 1; i < 4; i++) ref_mem[i] = 32'h0;
        end else begin
            if (rsp_valid2) rsp2_cnt++;
            if (mm_write_en || mm_read_en)
                check_eq("strobe_excl", 32'(mm_write_en & mm_read_en), 32'h0);
            if (status_valid) begin
                check_eq("status_word", status_word, ref_mem[1]);
                check_eq("error_word", error_word, ref_mem[2]);
            end
            if (rsp_valid) begin
                rsp_cnt++;
                check_eq("rsp_unexpected", 32'(sb.size() == 0), 32'h0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("rsp_rdata", rsp_rdata, e.rdata);
                    check_eq("rsp_cycle", cyc, e.due);
                    if (e.wr) begin
                        check_eq("wr_strobe", 32'(mm_write_en), 32'h1);
                        check_eq("wr_addr", 32'(mm_addr), 32'(e.addr));
                        check_eq("wr_data", mm_wdata, e.wdata);
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
                e.wr    = cmd_write;
                e.addr  = cmd_addr;
                e.wdata = cmd_wdata;
                if (cmd_write) begin
                    ref_mem[cmd_addr[1:0]] = cmd_wdata;
                    e.rdata = 32'h0;
                    e.due   = cyc + 1;
                end else begin
                    e.rdata = ref_mem[cmd_addr[1:0]];
                    e.due   = cyc + 2 + RDL;
                end
                sb.push_back(e);
            end
        end
    end

    task automatic wait_accept(output int unsigned c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 64);
        check_eq("accept_timeout", 32'(cmd_ready), 32'h1);
        c = cyc;
    endtask

    task automatic host_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d);
        int unsigned c;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        wait_accept(c);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_timeout", 32'(sb.size()), 32'h0);
    endtask

    task automatic wait_sv(output int unsigned c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!status_valid && n < 64);
        check_eq("sv_timeout", 32'(status_valid), 32'h1);
        c = cyc;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s1, s2, s3, a, sv_cnt;
        int          rsp_before;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 32'h0;
        cmd_valid2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_strobes", {30'h0, mm_write_en, mm_read_en}, 32'h0);
        check_eq("rst_mm_addr", 32'(mm_addr), 32'h0);
        check_eq("rst_mm_wdata", mm_wdata, 32'h0);
        check_eq("rst_rsp", {rsp_rdata[30:0], rsp_valid}, 32'h0);
        check_eq("rst_status", status_word | error_word, 32'h0);
        check_eq("rst_overrun", 32'(poll_overrun), 32'h0);

        @(posedge clk); #1;
        rst = 1'b0;
        cmd_valid2 = 1'b1;
        @(negedge clk);
        check_eq("boot_we", 32'(mm_write_en), 32'h1);
        check_eq("boot_addr", 32'(mm_addr), 32'h0);
        check_eq("boot_data", mm_wdata, 32'h0000_0001);
        check_eq("boot_ready", 32'(cmd_ready), 32'h0);
        @(negedge clk);
        check_eq("post_boot_ready", 32'(cmd_ready), 32'h1);
        check_eq("post_boot_we", 32'(mm_write_en), 32'h0);
        check_eq("post_boot_busy", 32'(busy), 32'h0);

        host_cmd(1'b1, 8'h00, 32'hABCD_1234);
        host_cmd(1'b0, 8'h00, 32'h0);
        host_cmd(1'b1, 8'h02, 32'h0403_0201);
        host_cmd(1'b0, 8'h02, 32'h0);
        host_cmd(1'b1, 8'h01, 32'h0000_0035);
        host_cmd(1'b1, 8'h02, 32'h1122_3344);
        host_cmd(1'b0, 8'h01, 32'h0);
        drain();

`ifdef MM_CFG_MASTER_AUTOPOLL_EN
        wait_sv(s1);
        wait_sv(s2);
        wait_sv(s3);
        check_eq("poll_period", s3 - s2, 32'(PER));

        // Request raised while the poll is pending: accepted in the status_valid cycle.
        repeat (11) @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h02;
        wait_accept(a);
        check_eq("contend_accept_cyc", a - s3, 32'd16);
        check_eq("contend_sv_same_cyc", 32'(status_valid), 32'h1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        drain();

        // Accept coinciding with the timer wrap: command first, poll right after.
        wait_sv(s1);
        repeat (10) @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h01;
        wait_accept(a);
        check_eq("wrap_accept_cyc", a - s1, 32'd10);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_sv(s2);
        check_eq("wrap_poll_after_cmd", s2 - s1, 32'd18);
        drain();
        check_eq("main_overrun", 32'(poll_overrun), 32'h0);
        check_eq("dut2_overrun", 32'(poll_overrun2), 32'h1);
`else
        sv_cnt = 0;
        repeat (3 * PER) begin
            @(negedge clk);
            if (status_valid) sv_cnt++;
        end
        check_eq("no_poll_sv", sv_cnt, 32'h0);
        check_eq("no_poll_status", status_word | error_word, 32'h0);
        check_eq("dut2_overrun", 32'(poll_overrun2), 32'h0);
`endif
        check_eq("dut2_rsp_seen", 32'(rsp2_cnt > 0), 32'h1);

        // Reset during CMD_WAIT: no response, boot write repeats.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h02;
        wait_accept(a);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("midrd_strobe", 32'(mm_read_en), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        rsp_before = rsp_cnt;
        @(negedge clk);
        check_eq("midrd_rst_outs", {29'h0, busy, rsp_valid, mm_read_en}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("reboot_we", 32'(mm_write_en), 32'h1);
        check_eq("reboot_addr", 32'(mm_addr), 32'h0);
        check_eq("reboot_data", mm_wdata, 32'h0000_0001);
        repeat (10) @(negedge clk);
        check_eq("midrd_no_rsp", rsp_cnt - rsp_before, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
